// File: rtl/clk_gen_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_gen_multi_if : configuration write channel for clk_gen_multi.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface clk_gen_multi_if #(
  parameter int CH_W      = 4,
  parameter int ACC_WIDTH = 24
);
  logic                 cfg_wr;
  logic [CH_W-1:0]      cfg_ch;
  logic [ACC_WIDTH-1:0] cfg_incr;
  logic                 cfg_ack;
  logic                 cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_incr, input cfg_ack, cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_incr, output cfg_ack, cfg_err);
endinterface
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_gen_multi : multi-channel fractional tick generator (phase accum.)   |
// | Optional macro CLK_GEN_SQUARE_OUT_EN adds the square_out toggle outputs. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module clk_gen_multi #(
  parameter int BOARD_FREQ = 50000000,
  parameter int OUT_FREQ   = 153600,
  parameter int CHANNELS   = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int OVERSAMPLE = 16,
  parameter int CH_W       = 4
) (
  input  logic                clk_board,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  clk_gen_multi_if.slave      cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] bit_tick
`ifdef CLK_GEN_SQUARE_OUT_EN
  ,
  output logic [CHANNELS-1:0] square_out
`else
  // toggle outputs not built in this configuration
`endif
);

  localparam longint c_def_wide = (longint'(OUT_FREQ) * (longint'(1) << ACC_WIDTH)
                                   + longint'(BOARD_FREQ) / 2) / longint'(BOARD_FREQ);
  localparam logic [ACC_WIDTH-1:0] c_def_incr = c_def_wide[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] c_half     = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam int                   c_sub_w    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [c_sub_w-1:0]   c_sub_last = c_sub_w'(OVERSAMPLE - 1);
  localparam int                   c_chw1     = CH_W + 1;
  localparam logic [CH_W:0]        c_nch      = c_chw1'(CHANNELS);

  logic                 w_ch_ok;
  logic [ACC_WIDTH-1:0] w_incr_clamped;
  logic                 r_ack;
  logic                 r_err;

  assign w_ch_ok        = ({1'b0, cfg.cfg_ch} < c_nch);
  // Increments above half scale would alias; cap at the board_freq/2 rate.
  assign w_incr_clamped = (cfg.cfg_incr > c_half) ? c_half : cfg.cfg_incr;

  always_ff @(posedge clk_board) begin
    if (!reset) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= cfg.cfg_wr && w_ch_ok;
      r_err <= cfg.cfg_wr && !w_ch_ok;
    end
  end

  assign cfg.cfg_ack = r_ack;
  assign cfg.cfg_err = r_err;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_incr;
    logic [c_sub_w-1:0]   r_sub;
    logic                 r_tick;
    logic                 r_bit;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_hit;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_incr};
    assign w_hit = cfg.cfg_wr && w_ch_ok && (cfg.cfg_ch == CH_W'(i));

    // A write on this channel takes priority over a carry in the same cycle.
    always_ff @(posedge clk_board) begin
      if (!reset) begin
        r_acc  <= '0;
        r_incr <= c_def_incr;
        r_sub  <= '0;
        r_tick <= 1'b0;
        r_bit  <= 1'b0;
      end else if (w_hit) begin
        r_acc  <= '0;
        r_incr <= w_incr_clamped;
        r_sub  <= '0;
        r_tick <= 1'b0;
        r_bit  <= 1'b0;
      end else if (enable[i]) begin
        r_acc  <= w_sum[ACC_WIDTH-1:0];
        r_tick <= w_sum[ACC_WIDTH];
        r_bit  <= w_sum[ACC_WIDTH] && (r_sub == c_sub_last);
        if (w_sum[ACC_WIDTH]) begin
          r_sub <= (r_sub == c_sub_last) ? '0 : r_sub + 1'b1;
        end
      end else begin
        r_tick <= 1'b0;
        r_bit  <= 1'b0;
      end
    end

    assign tick[i]     = r_tick;
    assign bit_tick[i] = r_bit;

`ifdef CLK_GEN_SQUARE_OUT_EN
    logic r_sq;

    always_ff @(posedge clk_board) begin
      if (!reset) begin
        r_sq <= 1'b0;
      end else if (w_hit) begin
        r_sq <= 1'b0;
      end else if (enable[i] && w_sum[ACC_WIDTH]) begin
        r_sq <= ~r_sq;
      end
    end

    assign square_out[i] = r_sq;
`else
    // no toggle flop without the square output
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_gen_multi : scoreboard bench for clk_gen_multi (8-bit acc, 2 ch). |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_clk_gen_multi;

  localparam int c_def_incr = 1;  // round(153600 * 256 / 50e6)

  typedef struct {
    int         cyc;
    logic [1:0] tick;
    logic [1:0] bits;
    logic       ack;
    logic       err;
    logic [1:0] sq;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] enable = 2'b00;
  logic [1:0] tick;
  logic [1:0] bit_tick;
`ifdef CLK_GEN_SQUARE_OUT_EN
  logic [1:0] square_out;
`endif

  clk_gen_multi_if #(.CH_W(4), .ACC_WIDTH(8)) cif ();

  clk_gen_multi #(
    .BOARD_FREQ(50000000), .OUT_FREQ(153600), .CHANNELS(2),
    .ACC_WIDTH(8), .OVERSAMPLE(16), .CH_W(4)
  ) dut (
    .clk_board (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg       (cif),
    .tick      (tick),
`ifdef CLK_GEN_SQUARE_OUT_EN
    .square_out(square_out),
`endif
    .bit_tick  (bit_tick)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   tick_cnt[2], bit_cnt[2], ack_cnt, err_cnt;
  int   b_tick[2], b_bit[2], b_ack, b_err;
  int   acc_m[2], inc_m[2], sub_m[2];
  logic sq_m[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, want);
    else
      n_pass++;
  endtask

  // Scoreboard: each driven cycle queues the outputs expected after its edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_value("cycle", 32'(cyc), 32'(mon_e.cyc));
      check_value("tick", 32'(tick), 32'(mon_e.tick));
      check_value("bit_tick", 32'(bit_tick), 32'(mon_e.bits));
      check_value("cfg_ack", 32'(cif.cfg_ack), 32'(mon_e.ack));
      check_value("cfg_err", 32'(cif.cfg_err), 32'(mon_e.err));
`ifdef CLK_GEN_SQUARE_OUT_EN
      check_value("square_out", 32'(square_out), 32'(mon_e.sq));
`endif
      for (int c = 0; c < 2; c++) begin
        if (tick[c] === 1'b1) tick_cnt[c]++;
        if (bit_tick[c] === 1'b1) bit_cnt[c]++;
      end
      if (cif.cfg_ack === 1'b1) ack_cnt++;
      if (cif.cfg_err === 1'b1) err_cnt++;
    end
  end

  task automatic drive(input logic rst_n, input logic [1:0] en, input logic wr,
                       input int ch, input int inc);
    exp_t e;
    @(negedge clk);
    #1;
    reset        = rst_n;
    enable       = en;
    cif.cfg_wr   = wr;
    cif.cfg_ch   = 4'(ch);
    cif.cfg_incr = 8'(inc);
    e.cyc = cyc + 1; e.tick = '0; e.bits = '0; e.ack = 1'b0; e.err = 1'b0;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        acc_m[c] = 0; inc_m[c] = c_def_incr; sub_m[c] = 0; sq_m[c] = 1'b0;
      end
    end else begin
      e.ack = wr && (ch < 2);
      e.err = wr && (ch >= 2);
      for (int c = 0; c < 2; c++) begin
        if (wr && ch == c) begin
          inc_m[c] = (inc > 128) ? 128 : inc;
          acc_m[c] = 0; sub_m[c] = 0; sq_m[c] = 1'b0;
        end else if (en[c]) begin
          acc_m[c] += inc_m[c];
          if (acc_m[c] >= 256) begin
            acc_m[c] -= 256;
            e.tick[c] = 1'b1;
            sq_m[c]   = ~sq_m[c];
            sub_m[c]++;
            if (sub_m[c] == 16) begin
              sub_m[c]  = 0;
              e.bits[c] = 1'b1;
            end
          end
        end
      end
    end
    e.sq = {sq_m[1], sq_m[0]};
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [1:0] en, input int n);
    repeat (n) drive(1'b1, en, 1'b0, 0, 0);
  endtask

  task automatic cfg_write(input int ch, input int inc, input logic [1:0] en);
    drive(1'b1, en, 1'b1, ch, inc);
  endtask

  // One idle cycle lets the monitor catch up before counters are snapshotted.
  task automatic flush_snap();
    drive(1'b1, 2'b00, 1'b0, 0, 0);
    b_tick = tick_cnt; b_bit = bit_cnt; b_ack = ack_cnt; b_err = err_cnt;
  endtask

  task automatic check_counts(input string tag, input int t0, input int t1,
                              input int bt0, input int bt1);
    drive(1'b1, 2'b00, 1'b0, 0, 0);
    check_value({tag, "_tick0"}, 32'(tick_cnt[0] - b_tick[0]), 32'(t0));
    check_value({tag, "_tick1"}, 32'(tick_cnt[1] - b_tick[1]), 32'(t1));
    check_value({tag, "_bit0"}, 32'(bit_cnt[0] - b_bit[0]), 32'(bt0));
    check_value({tag, "_bit1"}, 32'(bit_cnt[1] - b_bit[1]), 32'(bt1));
    b_tick = tick_cnt; b_bit = bit_cnt;
  endtask

  initial begin
    tick_cnt = '{0, 0}; bit_cnt = '{0, 0}; ack_cnt = 0; err_cnt = 0;
    cif.cfg_wr = 1'b0; cif.cfg_ch = '0; cif.cfg_incr = '0;
    for (int c = 0; c < 2; c++) begin
      acc_m[c] = 0; inc_m[c] = c_def_incr; sub_m[c] = 0; sq_m[c] = 1'b0;
    end

    repeat (3) drive(1'b0, 2'b00, 1'b0, 0, 0);
    flush_snap();

    // Default increment after reset: one carry per 256 cycles.
    run(2'b01, 256);
    check_counts("default", 1, 0, 0, 0);

    cfg_write(0, 64, 2'b01);
    run(2'b01, 128);
    check_counts("incr64", 32, 0, 2, 0);

    cfg_write(1, 96, 2'b10);
    run(2'b10, 24);
    check_counts("incr96", 0, 9, 0, 0);

    cfg_write(0, 200, 2'b01);
    run(2'b01, 40);
    check_counts("clamp", 20, 0, 1, 0);

    // Bad channel: ch0 keeps running from its held phase and sub-count.
    b_err = err_cnt; b_ack = ack_cnt;
    cfg_write(3, 5, 2'b01);
    run(2'b01, 23);
    check_counts("badch", 12, 0, 1, 0);
    check_value("badch_err", 32'(err_cnt - b_err), 32'd1);
    check_value("badch_ack", 32'(ack_cnt - b_ack), 32'd0);

    // Second write lands on the edge where ch0 would carry.
    cfg_write(0, 64, 2'b01);
    run(2'b01, 7);
    cfg_write(0, 128, 2'b01);
    run(2'b01, 8);
    check_counts("wr_on_carry", 5, 0, 0, 0);

    b_ack = ack_cnt;
    cfg_write(0, 32, 2'b11);
    cfg_write(1, 64, 2'b11);
    run(2'b11, 64);
    check_counts("b2b", 8, 16, 0, 1);
    check_value("b2b_ack", 32'(ack_cnt - b_ack), 32'd2);

    run(2'b11, 10);
    drive(1'b0, 2'b11, 1'b0, 0, 0);
    flush_snap();
    run(2'b01, 256);
    check_counts("after_reset", 1, 0, 0, 0);

    cfg_write(1, 0, 2'b10);
    run(2'b10, 100);
    check_counts("zero_incr", 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check_value("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
